// File: rtl/psmac_pkg.sv
// Shared constants and helpers for the precision-scalable MAC (psmac_accum).
// Element-mode encodings, lane product width and a constant-safe clog2.
package psmac_pkg;

    localparam logic [1:0] MODE_8B = 2'b00;
    localparam logic [1:0] MODE_4B = 2'b01;
    localparam logic [1:0] MODE_2B = 2'b10;

    localparam int LANE_PW = 18;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psmac_lane.sv
// Combinational per-byte multiplier: one 8x8, two 4x4 or four 2x2 products
// summed into an 18-bit signed lane result. Mode 2'b11 falls back to 8b.
module psmac_lane
    import psmac_pkg::*;
(
    input  logic [7:0]                i_ip,
    input  logic [7:0]                i_wt,
    input  logic [1:0]                i_mode,
    input  logic                      i_ip_signed,
    input  logic                      i_wt_signed,
    output logic signed [LANE_PW-1:0] o_sum
);

    logic signed [8:0]  w_a8;
    logic signed [8:0]  w_b8;
    logic signed [17:0] w_p8;
    logic signed [4:0]  w_a4 [2];
    logic signed [4:0]  w_b4 [2];
    logic signed [9:0]  w_p4 [2];
    logic signed [2:0]  w_a2 [4];
    logic signed [2:0]  w_b2 [4];
    logic signed [5:0]  w_p2 [4];

    // Each element gets one extra top bit: its sign when signed, zero otherwise.
    assign w_a8 = {i_ip_signed & i_ip[7], i_ip};
    assign w_b8 = {i_wt_signed & i_wt[7], i_wt};
    assign w_p8 = 18'(w_a8) * 18'(w_b8);

    for (genvar k = 0; k < 2; k++) begin : g_nib
        assign w_a4[k] = {i_ip_signed & i_ip[4*k+3], i_ip[4*k +: 4]};
        assign w_b4[k] = {i_wt_signed & i_wt[4*k+3], i_wt[4*k +: 4]};
        assign w_p4[k] = 10'(w_a4[k]) * 10'(w_b4[k]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_crumb
        assign w_a2[k] = {i_ip_signed & i_ip[2*k+1], i_ip[2*k +: 2]};
        assign w_b2[k] = {i_wt_signed & i_wt[2*k+1], i_wt[2*k +: 2]};
        assign w_p2[k] = 6'(w_a2[k]) * 6'(w_b2[k]);
    end

    always_comb begin
        case (i_mode)
            MODE_4B: o_sum = LANE_PW'(w_p4[0]) + LANE_PW'(w_p4[1]);
            MODE_2B: o_sum = LANE_PW'(w_p2[0]) + LANE_PW'(w_p2[1])
                           + LANE_PW'(w_p2[2]) + LANE_PW'(w_p2[3]);
            default: o_sum = w_p8;
        endcase
    end

endmodule

// File: rtl/psmac_accum.sv
// Pipelined precision-scalable dot-product accumulator with valid/ready output.
// Define PSMAC_SAT_EN for a saturating accumulator with a sticky out_sat flag.
module psmac_accum
    import psmac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [8*LANES-1:0]      ip,
    input  logic [8*LANES-1:0]      wt,
    input  logic [1:0]              mode,
    input  logic                    ip_signed,
    input  logic                    wt_signed,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_sat
);

    localparam int SUM_W = LANE_PW + clog2(LANES);

    logic signed [LANE_PW-1:0] w_lane [LANES];
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_beat;
    logic                      w_stall;
    logic                      w_accept;
    logic                      w_fire;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_clip;
    logic                      w_sat_nxt;

    logic signed [ACC_W-1:0]   r_sum_p1;
    logic                      r_last_p1;
    logic                      r_vld_p1;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_sat;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_out_data;
    logic [CNT_W-1:0]          r_out_beats;
    logic                      r_out_sat;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        psmac_lane u_lane (
            .i_ip        (ip[8*l +: 8]),
            .i_wt        (wt[8*l +: 8]),
            .i_mode      (mode),
            .i_ip_signed (ip_signed),
            .i_wt_signed (wt_signed),
            .o_sum       (w_lane[l])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + SUM_W'(w_lane[l]);
        end
    end

    assign w_beat   = ACC_W'(w_sum);
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;
    assign w_fire   = !w_stall && r_vld_p1 && !clr;

`ifdef PSMAC_SAT_EN
    function automatic logic signed [ACC_W:0] wide_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
        return (ACC_W+1)'(a) + (ACC_W+1)'(b);
    endfunction

    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    logic signed [ACC_W:0] w_wide;
    assign w_wide    = wide_add(r_acc, r_sum_p1);
    assign w_acc_nxt = saturate(w_wide);
    assign w_clip    = w_wide[ACC_W] ^ w_wide[ACC_W-1];
`else
    assign w_acc_nxt = r_acc + r_sum_p1;
    assign w_clip    = 1'b0;
`endif

    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_sat_nxt = r_sat | w_clip;

    // Stage 1: register the beat sum of an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p1  <= '0;
            r_last_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else if (clr) begin
            r_vld_p1  <= 1'b0;
        end else if (!w_stall) begin
            r_sum_p1  <= w_beat;
            r_last_p1 <= in_last;
            r_vld_p1  <= w_accept;
        end
    end

    // Stage 2: accumulate, and on the last beat hand the group to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_fire) begin
                if (r_last_p1) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_acc_nxt;
                    r_out_beats <= w_cnt_nxt;
                    r_out_sat   <= w_sat_nxt;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_sat       <= 1'b0;
                end else begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= w_cnt_nxt;
                    r_sat <= w_sat_nxt;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_psmac_accum.sv
// Directed self-checking bench for psmac_accum with ACC_W=20 so the
// saturation/wrap boundary is reachable in a handful of beats.
module tb_psmac_accum;

    localparam int LANES = 4;
    localparam int ACC_W = 20;
    localparam int CNT_W = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [8*LANES-1:0]      ip;
    logic [8*LANES-1:0]      wt;
    logic [1:0]              mode;
    logic                    ip_signed;
    logic                    wt_signed;
    logic                    clr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_beats;
    logic                    out_sat;

    int n_cmp = 0;
    int n_err = 0;

    psmac_accum #(.LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .ip        (ip),
        .wt        (wt),
        .mode      (mode),
        .ip_signed (ip_signed),
        .wt_signed (wt_signed),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] ib, input logic [7:0] wb, input logic [1:0] m,
                        input logic is, input logic ws, input logic lst);
        ip        = {LANES{ib}};
        wt        = {LANES{wb}};
        mode      = m;
        ip_signed = is;
        wt_signed = ws;
        in_last   = lst;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; ip = '0; wt = '0;
        mode = 2'b00; ip_signed = 1'b0; wt_signed = 1'b0; clr = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // 8b unsigned single beat: 4 * (2*3) = 24, valid one edge after S1
        beat(8'h02, 8'h03, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t1_latency_valid", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 24);
        chk("t1_beats", out_beats, 1);
        step();
        chk("t1_valid_drop", out_valid, 0);

        // 2b signed: (-1)*1 per crumb, -4 per lane, -16 total
        beat(8'hFF, 8'h55, 2'b10, 1'b1, 1'b1, 1'b1);
        step();
        chk("t2_data", out_data, -16);
        chk("t2_beats", out_beats, 1);
        step();

        // 4b unsigned 3-beat group, then back-to-back 1-beat 8b group
        beat(8'h11, 8'h22, 2'b01, 1'b0, 1'b0, 1'b0);
        beat(8'h11, 8'h22, 2'b01, 1'b0, 1'b0, 1'b0);
        beat(8'h11, 8'h22, 2'b01, 1'b0, 1'b0, 1'b1);
        beat(8'h01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, 48);
        chk("t3_beats", out_beats, 3);
        step();
        chk("t3b_valid", out_valid, 1);
        chk("t3b_data", out_data, 4);
        chk("t3b_beats", out_beats, 1);
        step();
        chk("t3b_valid_drop", out_valid, 0);

        // Backpressure: result 16 held, a waiting beat (36) must not enter early
        out_ready = 1'b0;
        beat(8'h02, 8'h02, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("t4_valid", out_valid, 1);
        chk("t4_in_ready", in_ready, 0);
        ip = {LANES{8'h03}}; wt = {LANES{8'h03}}; mode = 2'b00;
        ip_signed = 1'b0; wt_signed = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_data", out_data, 16);
            chk("t4_hold_in_ready", in_ready, 0);
        end
        chk("t4_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t4_valid_drop", out_valid, 0);
        step();
        chk("t4_next_valid", out_valid, 1);
        chk("t4_next_data", out_data, 36);
        chk("t4_next_beats", out_beats, 1);
        step();

        // clr flushes the partial group (4 already in acc)
        beat(8'h01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        beat(8'h01, 8'h05, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("t5_clr_data", out_data, 20);
        chk("t5_clr_beats", out_beats, 1);
        step();

        // Asynchronous reset mid-group loses the group
        beat(8'h01, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_beats", out_beats, 0);
        chk("t5_rst_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        beat(8'h01, 8'h05, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        chk("t5_after_rst_data", out_data, 20);
        chk("t5_after_rst_beats", out_beats, 1);
        step();

        // Mixed modes in one group: -24 (8b s*u) + 76 (4b s*u) + 24 (mode 11 as 8b)
        beat(8'hFE, 8'h03, 2'b00, 1'b1, 1'b0, 1'b0);
        beat(8'hF7, 8'h23, 2'b01, 1'b1, 1'b0, 1'b0);
        beat(8'h02, 8'h03, 2'b11, 1'b0, 1'b0, 1'b1);
        step();
        chk("t7_mixed_data", out_data, 76);
        chk("t7_mixed_beats", out_beats, 3);
        step();

        // 9 beats of 64516 overflow a 20-bit accumulator
        for (int i = 0; i < 9; i++) begin
            beat(8'h7F, 8'h7F, 2'b00, 1'b1, 1'b1, (i == 8));
        end
        step();
        chk("t6_beats", out_beats, 9);
`ifdef PSMAC_SAT_EN
        chk("t6_sat_data", out_data, 524287);
        chk("t6_sat_flag", out_sat, 1);
`else
        chk("t6_wrap_data", out_data, -467932);
        chk("t6_wrap_flag", out_sat, 0);
`endif
        step();
        chk("t6_valid_drop", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
